// File: rtl/dev_defs.sv
// rtl/dev_defs.sv - shared register offsets, mode codes and FSM encodings for the MMIO timer
//
// Word offsets within the timer window (addr[3:2]), CTRL field layout,
// MODE codes and the 2-bit FSM state encoding.

package dev_defs;

  // Word offsets, selected by addr[3:2]
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  // MODE codes; 1x is reserved and treated as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tmr_state_t;

  // CTRL[3:0] = {IM, MODE[1:0], EN}
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped countdown timer with interrupt on expiry
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   addr   - CPU byte address, bits [1:0] ignored
//   we     - store strobe, effective only inside the window
//   wdata  - store data
//   rdata  - combinational read data, 0 outside the window
//   hit    - addr decodes to CTRL, PRESET or COUNT
//   irq    - pending interrupt gated by CTRL.IM

module mmio_timer
  import dev_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  tmr_state_t state_q, state_d;
  tmr_ctrl_t  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        irq_pending_q;

  logic        pend_set;
  logic        pend_clr;
  logic        en_clr;

  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_preset;

  // Address decode: offset 3 inside the 16-byte block is not part of the window
  assign off       = addr[3:2];
  assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (off != 2'b11);
  assign wr_ctrl   = we && hit && (off == TMR_CTRL);
  assign wr_preset = we && hit && (off == TMR_PRESET);

  assign irq = irq_pending_q & ctrl_q.im;

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        TMR_CTRL:   rdata = {28'd0, ctrl_q};
        TMR_PRESET: rdata = preset_q;
        TMR_COUNT:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q.en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q.en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers COUNT==1 and COUNT==0 (PRESET of 0), so COUNT never wraps
          count_d  = 32'd0;
          pend_set = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          pend_clr = 1'b1;
          state_d  = LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ctrl_q        <= '0;
      preset_q      <= 32'd0;
      count_q       <= 32'd0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;

      // A bus write to CTRL overrides the one-shot auto-clear of EN
      if (wr_ctrl)     ctrl_q    <= tmr_ctrl_t'(wdata[3:0]);
      else if (en_clr) ctrl_q.en <= 1'b0;

      if (wr_preset) preset_q <= wdata;

      // Expiry beats a concurrent clearing write so no interrupt is lost
      if (pend_set)                               irq_pending_q <= 1'b1;
      else if (pend_clr || wr_ctrl || wr_preset)  irq_pending_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed self-checking bench for mmio_timer

module tb_mmio_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  mmio_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  logic [31:0] v;
  int          pulses;
  int          over;

  initial begin
    reset = 1'b1;
    addr  = 32'd0;
    we    = 1'b0;
    wdata = 32'd0;

    // 1. Reset held two cycles
    step();
    step();
    reset = 1'b0;
    rd(A_CTRL, v);   chk("rst_ctrl", v, 32'd0);
    rd(A_PRESET, v); chk("rst_preset", v, 32'd0);
    rd(A_COUNT, v);  chk("rst_count", v, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // 2. One-shot, PRESET=5, IM=1: COUNT=5 two edges after the CTRL write, irq at t+7
    wr(A_PRESET, 32'd5);
    rd(32'h0000_7F07, v); chk("preset_lowbits_ignored", v, 32'd5);
    wr(A_CTRL, 32'h0000_0009);
    rd(A_COUNT, v); chk("os_idle_count", v, 32'd0);
    step();
    rd(A_COUNT, v); chk("os_load_count", v, 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      rd(A_COUNT, v);
      chk($sformatf("os_count_%0d", i), v, 32'(5 - i));
      chk($sformatf("os_irq_%0d", i), {31'd0, irq}, (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) step();
    end
    step();
    rd(A_CTRL, v); chk("os_ctrl_en_cleared", v, 32'h0000_0008);
    step();
    step();
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    wr(A_PRESET, 32'd3);
    chk("os_irq_cleared_by_preset", {31'd0, irq}, 32'd0);

    // 3. Auto-reload, PRESET=3: one-cycle pulse every 5 cycles
    wr(A_CTRL, 32'h0000_000B);
    pulses = 0;
    over   = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq) pulses++;
      rd(A_COUNT, v);
      if (v > 32'd3) over++;
    end
    chk("ar_pulses", 32'(pulses), 32'd4);
    chk("ar_count_bounded", 32'(over), 32'd0);

    // 4. Pause mid-count, then restart reloads from PRESET
    wr(A_CTRL, 32'h0000_0000);
    wr(A_PRESET, 32'd10);
    for (int i = 0; i < 5; i++) step();
    wr(A_CTRL, 32'h0000_0009);
    for (int i = 0; i < 4; i++) step();
    rd(A_COUNT, v); chk("pause_pre_count", v, 32'd8);
    wr(A_CTRL, 32'h0000_0008);
    over = 0;
    for (int i = 0; i < 10; i++) begin
      rd(A_COUNT, v);
      if (v != 32'd7) over++;
      step();
    end
    chk("pause_hold_7", 32'(over), 32'd0);
    chk("pause_irq", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h0000_0009);
    step();
    rd(A_COUNT, v); chk("restart_load_cycle", v, 32'd7);
    step();
    rd(A_COUNT, v); chk("restart_reload", v, 32'd10);
    for (int i = 0; i < 9; i++) step();
    rd(A_COUNT, v); chk("restart_count_1", v, 32'd1);
    chk("restart_irq_before", {31'd0, irq}, 32'd0);
    step();
    chk("restart_irq_at_p_plus_2", {31'd0, irq}, 32'd1);

    // 5. IM=0 hides expiry; setting IM via CTRL clears the pending flag
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h0000_0001);
    for (int i = 0; i < 6; i++) step();
    rd(A_COUNT, v); chk("im0_count", v, 32'd0);
    rd(A_CTRL, v);  chk("im0_ctrl", v, 32'd0);
    chk("im0_irq", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h0000_0008);
    chk("im1_irq_now", {31'd0, irq}, 32'd0);
    step();
    chk("im1_irq_later", {31'd0, irq}, 32'd0);

    // 6. Reset mid-count in auto-reload, with a concurrent PRESET write
    wr(A_PRESET, 32'd6);
    wr(A_CTRL, 32'h0000_000B);
    for (int i = 0; i < 4; i++) step();
    rd(A_COUNT, v); chk("rst2_pre_count", v, 32'd4);
    reset = 1'b1;
    addr  = A_PRESET;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
    step();
    reset = 1'b0;
    we    = 1'b0;
    rd(A_CTRL, v);   chk("rst2_ctrl", v, 32'd0);
    rd(A_PRESET, v); chk("rst2_preset", v, 32'd0);
    rd(A_COUNT, v);  chk("rst2_count", v, 32'd0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    step();
    step();
    rd(A_COUNT, v);  chk("rst2_count_idle", v, 32'd0);
    wr(A_COUNT, 32'd9);
    rd(A_COUNT, v);  chk("count_ro", v, 32'd0);
    chk("count_hit", {31'd0, hit}, 32'd1);
    rd(32'h0000_7F10, v);
    chk("oow_rdata", v, 32'd0);
    chk("oow_hit", {31'd0, hit}, 32'd0);
    rd(32'h0000_7F0C, v);
    chk("off3_rdata", v, 32'd0);
    chk("off3_hit", {31'd0, hit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
